// File: rtl/rr_arb_mux.sv
// Multi-channel packet mux with one registered output stage.
// An internal round-robin or fixed-priority arbiter holds its grant until in_last.
module rr_arb_mux #(
    parameter int N        = 32,
    parameter int CHANNELS = 8,
    parameter int MODE     = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*N-1:0]         in_data,
    input  logic [CHANNELS-1:0]           in_valid,
    input  logic [CHANNELS-1:0]           in_last,
    output logic [CHANNELS-1:0]           in_ready,
    output logic [N-1:0]                  out_data,
    output logic                          out_last,
    output logic [$clog2(CHANNELS)-1:0]   out_sel,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          dbg_state_o
);
    localparam int SW = $clog2(CHANNELS);

    // Handshake: a beat moves on any interface in a cycle where its valid and
    // ready are both high at the rising edge; valid never waits on ready.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  lock_q, lock_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic [SW-1:0]  out_sel_q, out_sel_d;
    logic           out_valid_q, out_valid_d;

    logic           load;
    logic           grant_vld;
    logic [SW-1:0]  grant_ch;
    logic [SW-1:0]  search_start;
    logic [N-1:0]   sel_data;
    logic           sel_last;
    logic           sel_valid;
    logic           xfer;

    function automatic logic [SW-1:0] search_idx(input logic [SW-1:0] start, input int step);
        int raw;
        raw = int'(start) + step;
        if (raw >= CHANNELS) raw = raw - CHANNELS;
        return SW'(raw);
    endfunction

    assign load         = !out_valid_q || out_ready;
    assign search_start = (MODE == 0) ? ptr_q : '0;

    // While locked the grant is fixed, so in_ready never looks at in_valid.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        if (state_q == ST_LOCKED) begin
            grant_vld = 1'b1;
            grant_ch  = lock_q;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!grant_vld && in_valid[search_idx(search_start, i)]) begin
                    grant_vld = 1'b1;
                    grant_ch  = search_idx(search_start, i);
                end
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        in_ready  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (grant_ch == SW'(c)) begin
                sel_data    = in_data[c*N +: N];
                sel_last    = in_last[c];
                sel_valid   = in_valid[c];
                in_ready[c] = !rst && load && grant_vld;
            end
        end
    end

    assign xfer = !rst && load && grant_vld && sel_valid;

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_last_d  = sel_last;
            out_sel_d   = grant_ch;
            out_valid_d = 1'b1;
            if (sel_last) begin
                state_d = ST_IDLE;
                if (MODE == 0) begin
                    ptr_d = (grant_ch == SW'(CHANNELS - 1)) ? '0 : grant_ch + 1'b1;
                end
            end else begin
                state_d = ST_LOCKED;
                lock_d  = grant_ch;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lock_q      <= '0;
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign out_sel     = out_sel_q;
    assign out_valid   = out_valid_q;
    assign dbg_state_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: three instances (8ch round-robin, 8ch priority, 5ch round-robin)
// share random stimulus and are checked against a packet-level reference model.
module tb_rr_arb_mux;
    localparam int N  = 16;
    localparam int BW = N + 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [8*N-1:0] in_data;
    logic [7:0]     in_valid;
    logic [7:0]     in_last;
    logic           out_ready;

    logic [7:0]     ir [3];
    logic [4:0]     ir2;
    logic [N-1:0]   od [3];
    logic [2:0]     os [3];
    logic           ol [3];
    logic           ov [3];
    logic           ds [3];

    int n_tests = 0;
    int n_fail  = 0;

    // Beat held in each instance's output register: {last, sel[2:0], data}
    logic [BW-1:0] exp_q [3][$];
    bit            locked [3];
    int            lock_ch [3];
    int            ptr [3];

    rr_arb_mux #(.N(N), .CHANNELS(8), .MODE(0)) u_rr8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir[0]), .out_data(od[0]), .out_last(ol[0]), .out_sel(os[0]),
        .out_valid(ov[0]), .out_ready(out_ready), .dbg_state_o(ds[0])
    );

    rr_arb_mux #(.N(N), .CHANNELS(8), .MODE(1)) u_fp8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir[1]), .out_data(od[1]), .out_last(ol[1]), .out_sel(os[1]),
        .out_valid(ov[1]), .out_ready(out_ready), .dbg_state_o(ds[1])
    );

    rr_arb_mux #(.N(N), .CHANNELS(5), .MODE(0)) u_rr5 (
        .clk(clk), .rst(rst), .in_data(in_data[5*N-1:0]), .in_valid(in_valid[4:0]),
        .in_last(in_last[4:0]), .in_ready(ir2), .out_data(od[2]), .out_last(ol[2]),
        .out_sel(os[2]), .out_valid(ov[2]), .out_ready(out_ready), .dbg_state_o(ds[2])
    );

    assign ir[2] = {3'b000, ir2};

    function automatic int chans(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic int mode_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare one instance against the model, then advance the model by one edge.
    task automatic model_step(input int k);
        int            c_n;
        int            md;
        int            g;
        int            c;
        bit            found;
        bit            load;
        logic [7:0]    exp_rdy;
        logic [BW-1:0] beat;
        c_n = chans(k);
        md  = mode_of(k);
        if (exp_q[k].size() != 0) begin
            beat = exp_q[k][0];
            check($sformatf("u%0d.out_valid", k), 64'(ov[k]), 64'd1);
            check($sformatf("u%0d.out_data", k), 64'(od[k]), 64'(beat[N-1:0]));
            check($sformatf("u%0d.out_sel", k), 64'(os[k]), 64'(beat[N+2:N]));
            check($sformatf("u%0d.out_last", k), 64'(ol[k]), 64'(beat[N+3]));
        end else begin
            check($sformatf("u%0d.out_valid", k), 64'(ov[k]), 64'd0);
        end
        check($sformatf("u%0d.locked", k), 64'(ds[k]), 64'(locked[k]));

        if (rst) begin
            check($sformatf("u%0d.in_ready_rst", k), 64'(ir[k]), 64'd0);
            exp_q[k].delete();
            locked[k] = 1'b0;
            ptr[k]    = 0;
            return;
        end

        load  = (exp_q[k].size() == 0) || out_ready;
        found = 1'b0;
        g     = 0;
        if (locked[k]) begin
            found = 1'b1;
            g     = lock_ch[k];
        end else begin
            for (int j = 0; j < c_n; j++) begin
                c = (md == 0) ? (ptr[k] + j) % c_n : j;
                if (!found && in_valid[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
        end
        exp_rdy = (load && found) ? 8'(1 << g) : 8'd0;
        check($sformatf("u%0d.in_ready", k), 64'(ir[k]), 64'(exp_rdy));

        if (out_ready && exp_q[k].size() != 0) void'(exp_q[k].pop_front());
        if (load && found && in_valid[g]) begin
            exp_q[k].push_back({in_last[g], 3'(g), in_data[g*N +: N]});
            if (in_last[g]) begin
                locked[k] = 1'b0;
                if (md == 0) ptr[k] = (g + 1) % c_n;
            end else begin
                locked[k]  = 1'b1;
                lock_ch[k] = g;
            end
        end
    endtask

    task automatic step(input logic [7:0] vmask, input int v_pct, input int l_pct,
                        input int r_pct, input int rst_pct);
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            in_valid[c]       = vmask[c] && ($urandom_range(0, 99) < v_pct);
            in_last[c]        = ($urandom_range(0, 99) < l_pct);
            in_data[c*N +: N] = N'($urandom);
        end
        out_ready = ($urandom_range(0, 99) < r_pct);
        rst       = ($urandom_range(0, 99) < rst_pct);
        #1;
        for (int k = 0; k < 3; k++) model_step(k);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            locked[k]  = 1'b0;
            lock_ch[k] = 0;
            ptr[k]     = 0;
        end

        // Reset held with every channel requesting
        repeat (3) step(8'hFF, 100, 100, 100, 100);
        // Single-beat packets from all channels, free-flowing output
        repeat (20) step(8'hFF, 100, 100, 100, 0);
        // Multi-beat packets on ch2 with bubbles while ch5 keeps requesting
        repeat (40) step(8'b0010_0100, 70, 30, 100, 0);
        // Output stalled, then released
        repeat (4) step(8'hFF, 100, 50, 0, 0);
        repeat (6) step(8'hFF, 100, 50, 100, 0);
        // ch1 and ch6 only, single-beat
        repeat (20) step(8'b0100_0010, 100, 100, 100, 0);
        // ch0 and ch4 multi-beat with occasional reset
        repeat (60) step(8'b0001_0001, 90, 30, 80, 5);
        // Broad random traffic
        repeat (600) step(8'hFF, $urandom_range(10, 100), $urandom_range(10, 90),
                          $urandom_range(30, 100), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
